// File: rtl/line_mem_responder.sv
// Memory-side line responder: a 16 x 128-bit backing store that serves one
// line read/write at a time after a fixed latency, plus a combinational debug word port.
module line_mem_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned LINES   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   mem_req_addr,
  input  logic         mem_req_rw,
  input  logic         mem_req_valid,
  input  logic [127:0] mem_data_write,
  output logic [127:0] mem_data_read,
  output logic         mem_ready,
  input  logic [7:0]   mem_req_addr2,
  output logic [31:0]  data
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [3:0]   line_q, line_d;
  logic         rw_q, rw_d;
  logic [127:0] wdata_q, wdata_d;
  logic         ready_q, ready_d;
  logic [127:0] rdata_q, rdata_d;
  logic [127:0] mem_q [LINES];
  logic [127:0] mem_d [LINES];

  logic [127:0] dbg_line;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req_valid) begin
          line_d  = mem_req_addr[7:4];
          rw_d    = mem_req_rw;
          wdata_d = mem_data_write;
          cnt_d   = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = RESP;
            ready_d = 1'b1;
            // nothing else is in flight, so the array is stable here
            if (!mem_req_rw)
              rdata_d = mem_q[mem_req_addr[7:4]];
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = RESP;
          ready_d = 1'b1;
          if (!rw_q)
            rdata_d = mem_q[line_q];
        end
      end
      RESP: begin
        state_d = IDLE;
        if (rw_q)
          mem_d[line_q] = wdata_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      line_q  <= 4'd0;
      rw_q    <= 1'b0;
      wdata_q <= 128'd0;
      ready_q <= 1'b0;
      rdata_q <= 128'd0;
      for (int i = 0; i < LINES; i++)
        mem_q[i] <= 128'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < LINES; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  assign dbg_line      = mem_q[mem_req_addr2[7:4]];
  assign data          = dbg_line[{mem_req_addr2[3:2], 5'd0} +: 32];
  assign mem_ready     = ready_q;
  assign mem_data_read = rdata_q;

endmodule
